// File: rtl/control_pkg.sv
// Control-state types shared by the front-end pipeline blocks.
package control_pkg;
  typedef enum logic {ST_RUN, ST_DISCARD} e_fb_state;
endpackage

// File: rtl/instructions_pkg.sv
// Instruction-side constants and the IF->ID queue entry layout.
package instructions_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_pls4;
    logic [31:0]     inst;
  } fb_entry_t;
endpackage

// File: rtl/fetch_decode_buffer_if.sv
// IF->ID handshake bundle: memory response, redirect, decode handshake and fetch back-pressure.
interface fetch_decode_buffer_if;
  import instructions_pkg::*;

  logic            inst_request;
  logic            inst_rvalid;
  logic [31:0]     inst_rdata;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_pls4_in;
  logic            redirect;
  logic            dec_ready;
  logic            dec_valid;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_pls4;
  logic            fetch_hold;
  logic            protocol_err;

  modport master (
    output inst_request, inst_rvalid, inst_rdata, pc_in, pc_pls4_in, redirect, dec_ready,
    input  dec_valid, dec_inst, dec_pc, dec_pc_pls4, fetch_hold, protocol_err
  );

  modport slave (
    input  inst_request, inst_rvalid, inst_rdata, pc_in, pc_pls4_in, redirect, dec_ready,
    output dec_valid, dec_inst, dec_pc, dec_pc_pls4, fetch_hold, protocol_err
  );
endinterface

// File: rtl/fetch_buf_fifo.sv
// Generic synchronous FIFO: registered write, combinational head read, synchronous clear.
module fetch_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_reg, tail_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign rdata = mem[head_reg];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | pop) & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail_reg] <= wdata;
  end
endmodule

// File: rtl/fetch_decode_buffer.sv
// IF->ID queue: captures memory responses with their PCs, throttles fetch, and drops in-flight responses after a redirect.
module fetch_decode_buffer
  import instructions_pkg::*;
  import control_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  fetch_decode_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);

  e_fb_state     state_reg;
  logic [CW-1:0] outstanding_reg, discard_reg, discard_calc;
  logic          protocol_err_reg;

  fb_entry_t     fifo_wdata, fifo_rdata;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          head_valid, pop_req, pop, push_req, overflow, req_acc;
  logic [SW-1:0] hold_sum;

  assign fifo_wdata = '{pc: bus.pc_in, pc_pls4: bus.pc_pls4_in, inst: bus.inst_rdata};

  fetch_buf_fifo #(.WIDTH($bits(fb_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (pop),
    .clear (bus.redirect),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign head_valid = ~fifo_empty;
  assign pop_req    = head_valid & bus.dec_ready;
  assign pop        = pop_req & ~bus.redirect;
  assign push_req   = bus.inst_rvalid & (state_reg == ST_RUN) & ~bus.redirect;
  assign overflow   = push_req & fifo_full & ~pop;

  // Slots already promised to in-flight requests count as taken.
  assign hold_sum       = {1'b0, fifo_count} + {1'b0, outstanding_reg} - SW'(pop_req);
  assign bus.fetch_hold = (hold_sum >= DEPTH_S) || (state_reg == ST_DISCARD);
  assign req_acc        = bus.inst_request & ~bus.fetch_hold;

  // A response arriving together with the redirect is already dropped, so it needs no discard slot.
  assign discard_calc = (bus.inst_rvalid && outstanding_reg != '0) ? outstanding_reg - 1'b1
                                                                   : outstanding_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg        <= ST_RUN;
      outstanding_reg  <= '0;
      discard_reg      <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      case ({req_acc, bus.inst_rvalid})
        2'b10: begin
          if (outstanding_reg == MAX_OUT_C) protocol_err_reg <= 1'b1;
          else                              outstanding_reg  <= outstanding_reg + 1'b1;
        end
        2'b01: begin
          if (outstanding_reg == '0) protocol_err_reg <= 1'b1;
          else                       outstanding_reg  <= outstanding_reg - 1'b1;
        end
        default: outstanding_reg <= outstanding_reg;
      endcase

      if (overflow) protocol_err_reg <= 1'b1;

      if (bus.redirect) begin
        discard_reg <= discard_calc;
        state_reg   <= (discard_calc != '0) ? ST_DISCARD : ST_RUN;
      end else if (state_reg == ST_DISCARD && bus.inst_rvalid && discard_reg != '0) begin
        discard_reg <= discard_reg - 1'b1;
        if (discard_reg == CW'(1)) state_reg <= ST_RUN;
      end
    end
  end

  assign bus.dec_valid    = head_valid;
  assign bus.dec_inst     = head_valid ? fifo_rdata.inst    : NOP_INST;
  assign bus.dec_pc       = head_valid ? fifo_rdata.pc      : '0;
  assign bus.dec_pc_pls4  = head_valid ? fifo_rdata.pc_pls4 : '0;
  assign bus.protocol_err = protocol_err_reg;
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed stimulus for the IF->ID queue with a queue-based scoreboard checked by an independent monitor.
module tb_fetch_decode_buffer;
  import instructions_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;
  fb_entry_t exp_q[$];

  fetch_decode_buffer_if bus();

  fetch_decode_buffer #(.DEPTH(2), .MAX_OUT(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Advance one clock; pulse-type inputs fall back to idle afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    bus.inst_request = 1'b0;
    bus.inst_rvalid  = 1'b0;
    bus.redirect     = 1'b0;
  endtask

  task automatic resp(input logic [31:0] data, input logic [31:0] pc, input bit expect_it);
    fb_entry_t e;
    bus.inst_rvalid = 1'b1;
    bus.inst_rdata  = data;
    bus.pc_in       = pc;
    bus.pc_pls4_in  = pc + 32'd4;
    if (expect_it) begin
      e.inst    = data;
      e.pc      = pc;
      e.pc_pls4 = pc + 32'd4;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: consumes expected entries whenever decode takes the head.
  initial begin
    fb_entry_t e;
    forever begin
      @(negedge clk);
      if (!rstn || bus.redirect) begin
        exp_q.delete();
      end else if (bus.dec_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got inst %h pc %h, expected no entry", bus.dec_inst, bus.dec_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst", bus.dec_inst, e.inst);
          chk("sb_pc", bus.dec_pc, e.pc);
          chk("sb_pc_pls4", bus.dec_pc_pls4, e.pc_pls4);
        end
      end else if (!bus.dec_valid) begin
        chk("idle_inst_nop", bus.dec_inst, NOP_INST);
        chk("idle_pc_zero", bus.dec_pc, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.inst_request = 1'b0;
    bus.inst_rvalid  = 1'b0;
    bus.inst_rdata   = '0;
    bus.pc_in        = '0;
    bus.pc_pls4_in   = '0;
    bus.redirect     = 1'b0;
    bus.dec_ready    = 1'b0;

    // Reset, then idle
    step(); step();
    rstn = 1'b1;
    step();
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_inst", bus.dec_inst, 32'h0000_0013);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_dec_pc_pls4", bus.dec_pc_pls4, 32'h0);
    chk("rst_fetch_hold", 32'(bus.fetch_hold), 32'd0);
    chk("rst_protocol_err", 32'(bus.protocol_err), 32'd0);

    // Streaming with dec_ready=1
    bus.dec_ready = 1'b1;
    bus.inst_request = 1'b1;
    step();
    bus.inst_request = 1'b1;
    resp(32'h0050_0093, 32'h0, 1'b1);
    chk("stream_hold0", 32'(bus.fetch_hold), 32'd0);
    step();
    chk("stream_lat_inst0", bus.dec_inst, 32'h0050_0093);
    chk("stream_lat_pc0", bus.dec_pc, 32'h0);
    chk("stream_lat_pls4_0", bus.dec_pc_pls4, 32'h4);
    resp(32'h0060_0113, 32'h4, 1'b1);
    chk("stream_hold1", 32'(bus.fetch_hold), 32'd0);
    step();
    chk("stream_lat_inst1", bus.dec_inst, 32'h0060_0113);
    chk("stream_lat_pc1", bus.dec_pc, 32'h4);
    chk("stream_lat_pls4_1", bus.dec_pc_pls4, 32'h8);
    step();
    chk("stream_drained", 32'(bus.dec_valid), 32'd0);

    // Back-pressure with dec_ready=0
    bus.dec_ready = 1'b0;
    bus.inst_request = 1'b1;
    chk("bp_hold_empty", 32'(bus.fetch_hold), 32'd0);
    step();
    bus.inst_request = 1'b1;
    resp(32'h0070_0193, 32'h8, 1'b1);
    chk("bp_hold_sum1", 32'(bus.fetch_hold), 32'd0);
    step();
    chk("bp_hold_sum2", 32'(bus.fetch_hold), 32'd1);
    resp(32'h0080_0213, 32'hC, 1'b1);
    step();
    chk("bp_hold_full", 32'(bus.fetch_hold), 32'd1);
    chk("bp_head_inst", bus.dec_inst, 32'h0070_0193);
    step();
    chk("bp_hold_stays", 32'(bus.fetch_hold), 32'd1);
    bus.dec_ready = 1'b1;
    #1;
    chk("bp_hold_release", 32'(bus.fetch_hold), 32'd0);
    step();
    step();
    chk("bp_drained", 32'(bus.dec_valid), 32'd0);

    // Redirect with two outstanding requests
    bus.inst_request = 1'b1;
    step();
    bus.inst_request = 1'b1;
    step();
    bus.redirect = 1'b1;
    step();
    chk("rd2_hold_discard", 32'(bus.fetch_hold), 32'd1);
    resp(32'hDEAD_BEEF, 32'h80, 1'b0);
    step();
    chk("rd2_hold_discard2", 32'(bus.fetch_hold), 32'd1);
    resp(32'hCAFE_BABE, 32'h84, 1'b0);
    step();
    chk("rd2_back_to_run", 32'(bus.fetch_hold), 32'd0);
    chk("rd2_nothing_shown", 32'(bus.dec_valid), 32'd0);
    bus.inst_request = 1'b1;
    step();
    resp(32'h0090_0293, 32'h100, 1'b1);
    step();
    chk("rd2_next_inst", bus.dec_inst, 32'h0090_0293);
    chk("rd2_next_pc", bus.dec_pc, 32'h100);
    step();

    // Redirect with a response in the same cycle, one outstanding, and a pop request on a flushed head
    bus.dec_ready = 1'b0;
    bus.inst_request = 1'b1;
    step();
    bus.inst_request = 1'b1;
    resp(32'h00A0_0313, 32'h20, 1'b1);
    step();
    chk("rd1_head_present", 32'(bus.dec_valid), 32'd1);
    bus.dec_ready = 1'b1;
    bus.redirect  = 1'b1;
    resp(32'hBADC_0DE5, 32'h24, 1'b0);
    step();
    chk("rd1_flushed", 32'(bus.dec_valid), 32'd0);
    chk("rd1_stays_run", 32'(bus.fetch_hold), 32'd0);
    chk("rd1_no_err", 32'(bus.protocol_err), 32'd0);
    bus.inst_request = 1'b1;
    step();
    resp(32'h00B0_0393, 32'h200, 1'b1);
    step();
    chk("rd1_next_inst", bus.dec_inst, 32'h00B0_0393);
    step();

    // Response with nothing outstanding
    resp(32'h1234_5678, 32'h40, 1'b1);
    step();
    chk("perr_set", 32'(bus.protocol_err), 32'd1);
    step(); step();
    chk("perr_sticky", 32'(bus.protocol_err), 32'd1);

    // Reset mid-operation drops a resident entry and clears the error
    bus.dec_ready = 1'b0;
    bus.inst_request = 1'b1;
    step();
    resp(32'h00C0_0413, 32'h44, 1'b0);
    step();
    chk("mid_entry_present", 32'(bus.dec_valid), 32'd1);
    rstn = 1'b0;
    step();
    chk("mid_rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("mid_rst_err", 32'(bus.protocol_err), 32'd0);
    chk("mid_rst_hold", 32'(bus.fetch_hold), 32'd0);
    rstn = 1'b1;
    bus.dec_ready = 1'b1;
    step(); step();

    chk("sb_all_delivered", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
